// File: rtl/cv32e40p_obi_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_obi_mem_pkg
// Description : Shared types and constants for the OBI data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package cv32e40p_obi_mem_pkg;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } obi_resp_t;

    localparam logic [31:0] OOR_RDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/cv32e40p_obi_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_obi_resp_fifo
// Description : DEPTH-entry in-order response FIFO, async active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_obi_resp_fifo
    import cv32e40p_obi_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = obi_resp_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  T                         i_push_data,
    input  logic                     i_pop,
    output T                         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned c_PW = $clog2(DEPTH);

    T                r_mem [DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_PW:0]   r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == (c_PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/cv32e40p_obi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_obi_mem_responder
// Description : OBI data-memory subordinate: word RAM, throttled grants and
//               in-order responses. Optional err_o: CV32E40P_OBI_RESP_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_obi_mem_responder
    import cv32e40p_obi_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] OOR_RDATA = OOR_RDATA_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
`ifdef CV32E40P_OBI_RESP_ERR_EN
    output logic        err_o,
`endif
    input  logic        gnt_stall_i,
    input  logic        resp_stall_i
);

    localparam int unsigned c_AW = $clog2(MEM_WORDS);
    localparam int unsigned c_CW = $clog2(DEPTH) + 1;

`ifdef CV32E40P_OBI_RESP_ERR_EN
    typedef obi_resp_t entry_t;
`else
    typedef logic [31:0] entry_t;
`endif

    logic [31:0]     r_mem [MEM_WORDS];
    logic            w_hs;
    logic            w_oor;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic [c_AW-1:0] w_idx;
    logic [31:0]     w_push_rdata;
    logic [31:0]     w_head_rdata;
    logic [c_CW-1:0] w_count;
    entry_t          w_push_data;
    entry_t          w_head;
    logic            w_unused;

    assign w_unused = &{1'b0, addr_i[1:0]};

    // A pop in the same cycle does not free a slot: grant looks at full only.
    assign gnt_o = req_i & ~gnt_stall_i & ~w_full & ~rst_i;
    assign w_hs  = req_i & gnt_o;
    assign w_oor = {2'b00, addr_i[31:2]} >= 32'(MEM_WORDS);
    assign w_idx = addr_i[c_AW+1:2];

    // Read data is snapshotted at the grant edge, before any same-edge write.
    assign w_push_rdata = we_i  ? 32'h0 :
                          w_oor ? OOR_RDATA : r_mem[w_idx];

    always_ff @(posedge clk_i) begin
        if (w_hs && we_i && !w_oor) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) r_mem[w_idx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

`ifdef CV32E40P_OBI_RESP_ERR_EN
    assign w_push_data  = '{rdata: w_push_rdata, err: w_oor};
    assign w_head_rdata = w_head.rdata;
    assign err_o        = rvalid_o & w_head.err;
`else
    assign w_push_data  = w_push_rdata;
    assign w_head_rdata = w_head;
`endif

    cv32e40p_obi_resp_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_resp_fifo (
        .clk         (clk_i),
        .rst         (rst_i),
        .i_push      (w_hs),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    assign rvalid_o = ~w_empty & ~resp_stall_i;
    assign w_pop    = rvalid_o;
    assign rdata_o  = rvalid_o ? w_head_rdata : 32'h0;

    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(w_hs && (w_count == c_CW'(DEPTH))));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i)
        !(w_pop && (w_count == '0)));
    a_req_known: assert property (@(posedge clk_i) disable iff (rst_i)
        !$isunknown(req_i));

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_obi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cv32e40p_obi_mem_responder
// Description : Self-checking bench against a queue/array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_obi_mem_responder;

    localparam int unsigned MEM_WORDS = 64;
    localparam int unsigned DEPTH     = 4;

    typedef struct {
        logic [31:0] d;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
`ifdef CV32E40P_OBI_RESP_ERR_EN
    logic        err_o;
`endif
    logic        gnt_stall_i;
    logic        resp_stall_i;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] ref_mem [MEM_WORDS];
    exp_t        exp_q [$];

    always #5 clk = ~clk;

    cv32e40p_obi_mem_responder #(
        .MEM_WORDS (MEM_WORDS),
        .DEPTH     (DEPTH),
        .OOR_RDATA (32'hDEAD_BEEF)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .gnt_o        (gnt_o),
        .addr_i       (addr_i),
        .we_i         (we_i),
        .be_i         (be_i),
        .wdata_i      (wdata_i),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
`ifdef CV32E40P_OBI_RESP_ERR_EN
        .err_o        (err_o),
`endif
        .gnt_stall_i  (gnt_stall_i),
        .resp_stall_i (resp_stall_i)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Compare outputs with the model, then advance the model by one clock edge.
    task automatic model_cycle();
        int          n;
        logic        eg;
        logic        ev;
        logic [31:0] widx;
        logic        oor;
        exp_t        r;
        n  = exp_q.size();
        eg = req_i & ~gnt_stall_i & (n < DEPTH) & ~rst_i;
        ev = (n != 0) & ~resp_stall_i & ~rst_i;
        check_eq("gnt", {31'b0, gnt_o}, {31'b0, eg});
        check_eq("rvalid", {31'b0, rvalid_o}, {31'b0, ev});
        check_eq("rdata", rdata_o, ev ? exp_q[0].d : 32'h0);
`ifdef CV32E40P_OBI_RESP_ERR_EN
        check_eq("err", {31'b0, err_o}, {31'b0, ev & exp_q[0].e});
`endif
        if (ev) void'(exp_q.pop_front());
        if (eg) begin
            widx = {2'b00, addr_i[31:2]};
            oor  = (widx >= MEM_WORDS);
            r.e  = oor;
            if (we_i) begin
                r.d = 32'h0;
                if (!oor)
                    for (int b = 0; b < 4; b++)
                        if (be_i[b]) ref_mem[widx][8*b +: 8] = wdata_i[8*b +: 8];
            end else begin
                r.d = oor ? 32'hDEAD_BEEF : ref_mem[widx];
            end
            exp_q.push_back(r);
        end
    endtask

    task automatic step(input logic req, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd,
                        input logic gs, input logic rs);
        @(negedge clk);
        req_i = req; we_i = we; addr_i = addr; be_i = be; wdata_i = wd;
        gnt_stall_i = gs; resp_stall_i = rs;
        #1;
        model_cycle();
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] a;
        rst_i = 1'b1; req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0; be_i = 4'h0;
        wdata_i = 32'h0; gnt_stall_i = 1'b0; resp_stall_i = 1'b0;
        #1;
        check_eq("rst_gnt", {31'b0, gnt_o}, 32'h0);
        check_eq("rst_rvalid", {31'b0, rvalid_o}, 32'h0);
        check_eq("rst_rdata", rdata_o, 32'h0);
        @(negedge clk);
        rst_i = 1'b0; req_i = 1'b0;

        for (int w = 0; w < MEM_WORDS; w++)
            step(1'b1, 1'b1, 32'(w * 4), 4'hF, $urandom, 1'b0, 1'b0);
        idle(2);

        // Back-to-back write then read of the same word.
        step(1'b1, 1'b1, 32'h10, 4'hF, 32'h1234_5678, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0, 1'b0);
        idle(2);

        // Partial write merges into the preloaded word.
        step(1'b1, 1'b1, 32'h20, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h20, 4'b0101, 32'h0011_2233, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0, 1'b0);
        idle(1);
        check_eq("partial_rdata", rdata_o, 32'hFF11_FF33);
        idle(1);

        // Backpressure: only DEPTH grants while responses are held.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0, 1'b1);
        check_eq("bp_full_gnt", {31'b0, gnt_o}, 32'h0);
        // Full with a simultaneous pop: no grant this cycle, grant next.
        step(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0, 1'b0);
        check_eq("full_pop_gnt", {31'b0, gnt_o}, 32'h0);
        step(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0, 1'b0);
        check_eq("after_pop_gnt", {31'b0, gnt_o}, 32'h1);
        idle(6);

        // Out-of-range read and dropped write aliasing word 0.
        step(1'b1, 1'b0, 32'(MEM_WORDS * 4), 4'h0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'(MEM_WORDS * 4), 4'hF, 32'hCAFE_F00D, 1'b0, 1'b0);
        check_eq("oor_rdata", rdata_o, 32'hDEAD_BEEF);
        step(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        idle(3);

        // Reset with three pending responses.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'(i * 4), 4'h0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b0; resp_stall_i = 1'b0; gnt_stall_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        check_eq("midrst_gnt", {31'b0, gnt_o}, 32'h0);
        check_eq("midrst_rvalid", {31'b0, rvalid_o}, 32'h0);
        check_eq("midrst_rdata", rdata_o, 32'h0);
        exp_q.delete();
        step(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_i = 1'b0; req_i = 1'b0;
        idle(2);
        step(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0, 1'b0);
        idle(1);
        idle(1);

        // Randomized traffic with throttling and occasional out-of-range access.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(7) == 0) a = 32'(($urandom_range(MEM_WORDS + 7)) * 4) | $urandom_range(3);
            else if ($urandom_range(31) == 0) a = $urandom;
            else a = 32'($urandom_range(MEM_WORDS - 1) * 4);
            step($urandom_range(3) != 0, $urandom_range(1) == 1, a, 4'($urandom),
                 $urandom, $urandom_range(4) == 0, $urandom_range(3) == 0);
        end
        idle(8);
        check_eq("drain_empty", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
